bcd_scan_counter: RTL and testbench

BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_digit.sv | 59 +++++
 rtl/bcd_scan_counter.sv | 129 ++++++++++++
 tb/tb_bcd_scan_counter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and constants for the four-decade BCD counter.
//   bcd_digit_t  - one packed BCD decade (valid codes 0..9)
//   BCD_MAX      - largest legal BCD code
//   NUM_DIGITS   - decades in the counter / positions on the display scan
//   bcd_sanitize - maps any non-decimal code (A..F) to 0
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX    = 4'd9;
    localparam int         NUM_DIGITS = 4;

    function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t d);
        return (d > BCD_MAX) ? bcd_digit_t'(0) : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one decade of a ripple BCD up/down counter.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset (value -> 0)
//   en         - global run enable (held low until reset release is synchronised)
//   up         - 1 = count up (carry), 0 = count down (borrow)
//   clr        - synchronous clear, highest priority
//   load       - synchronous load of load_val (non-decimal codes load as 0)
//   load_val   - BCD value to load
//   cin        - step request from the lower decade (or the tick strobe)
//   value      - current BCD value of this decade
//   cout       - step request to the next decade: this decade rolls over on this step
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       up,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       cin,
    output logic [3:0] value,
    output logic       cout
);

    bcd_digit_t value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (en) begin
            if (clr) begin
                value_d = '0;
            end else if (load) begin
                value_d = bcd_sanitize(load_val);
            end else if (cin) begin
                if (up) begin
                    value_d = (value_q >= BCD_MAX) ? bcd_digit_t'(0) : value_q + 4'd1;
                end else begin
                    value_d = (value_q == 4'd0) ? BCD_MAX : value_q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    // Ripple: the next decade steps only when this one rolls over on this step.
    // The top level masks the final carry with clr/load for the wrap flag.
    assign cout  = cin & (up ? (value_q == BCD_MAX) : (value_q == 4'd0));
    assign value = value_q;

endmodule

// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter: four-decade BCD up/down counter with a multiplexed
// seven-segment scan output.
// Ports:
//   clk       - sole clock, rising edge
//   rst_n     - asynchronous active-low reset, release synchronised internally
//   tick      - count-step strobe (one step per cycle it is high)
//   up        - direction, 1 = increment, 0 = decrement
//   clr       - synchronous clear (beats load and tick)
//   load      - synchronous load of load_val (beats tick)
//   load_val  - four BCD digits, [15:12] thousands .. [3:0] units
//   count     - current BCD count, same packing as load_val
//   W,X,Y,Z   - registered BCD of the scanned digit, W = MSB
//   dig_sel   - one-hot digit enable, bit 0 = units
//   wrap      - one-cycle pulse after 9999->0000 or 0000->9999
// Parameter SCAN_DIV: clk cycles each digit stays on the scan outputs.
module bcd_scan_counter
    import bcd_pkg::*;
#(
    parameter int SCAN_DIV = 50000
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        up,
    input  logic        clr,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] count,
    output logic        W,
    output logic        X,
    output logic        Y,
    output logic        Z,
    output logic [3:0]  dig_sel,
    output logic        wrap
);

    localparam int PW    = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    // Reset release synchroniser: assertion is immediate through the async
    // reset, release becomes visible as run=1 after two rising edges.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       run;

    logic [NUM_DIGITS:0] carry;
    logic [3:0]          digit_val [NUM_DIGITS];

    logic             wrap_q, wrap_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
    logic [3:0]       wxyz_q, wxyz_d;
    logic             presc_last;

    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign run        = rst_sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    // Decade chain: the tick strobe is the carry-in of the units digit.
    assign carry[0] = tick;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            bcd_digit u_digit (
                .clk      (clk),
                .rst_n    (rst_n),
                .en       (run),
                .up       (up),
                .clr      (clr),
                .load     (load),
                .load_val (load_val[gi*4 +: 4]),
                .cin      (carry[gi]),
                .value    (digit_val[gi]),
                .cout     (carry[gi+1])
            );
            assign count[gi*4 +: 4] = digit_val[gi];
            assign dig_sel[gi]      = (scan_idx_q == IDX_W'(gi));
        end
    endgenerate

    assign presc_last = (presc_q == PRESC_LAST);

    always_comb begin
        // A carry out of the thousands digit is a full-range rollover, but only
        // when the tick was actually applied (clr/load take precedence).
        wrap_d     = run & carry[NUM_DIGITS] & ~clr & ~load;
        presc_d    = presc_q;
        scan_idx_d = scan_idx_q;
        wxyz_d     = wxyz_q;
        if (run) begin
            presc_d = presc_last ? '0 : presc_q + 1'b1;
            if (presc_last) begin
                scan_idx_d = scan_idx_q + 1'b1;
            end
            // Select with the next index so the registered nibble changes in
            // the same cycle as dig_sel; it trails count by exactly one cycle.
            wxyz_d = digit_val[scan_idx_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_q     <= 1'b0;
            presc_q    <= '0;
            scan_idx_q <= '0;
            wxyz_q     <= '0;
        end else begin
            wrap_q     <= wrap_d;
            presc_q    <= presc_d;
            scan_idx_q <= scan_idx_d;
            wxyz_q     <= wxyz_d;
        end
    end

    assign wrap = wrap_q;
    assign W    = wxyz_q[3];
    assign X    = wxyz_q[2];
    assign Y    = wxyz_q[1];
    assign Z    = wxyz_q[0];

endmodule

// File: tb/tb_bcd_scan_counter.sv
module tb_bcd_scan_counter;

    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        up = 1'b1;
    logic        clr = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_val = 16'h0000;
    logic [15:0] count;
    logic        W, X, Y, Z;
    logic [3:0]  dig_sel;
    logic        wrap;

    bcd_scan_counter #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .up       (up),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .W        (W),
        .X        (X),
        .Y        (Y),
        .Z        (Z),
        .dig_sel  (dig_sel),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        string       name;
        bit          chk_cnt;
        logic [15:0] cnt;
        bit          chk_wrap;
        logic        wr;
        bit          chk_scan;
        logic [3:0]  sel;
        logic [3:0]  wxyz;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic async_chk = 1'b0;
    exp_t mon_e;

    function automatic void push(input int c, input string nm,
                                 input bit cc, input logic [15:0] cnt,
                                 input bit cw, input logic wr,
                                 input bit cs, input logic [3:0] sel, input logic [3:0] wx);
        exp_t e;
        e.cyc = c; e.name = nm;
        e.chk_cnt = cc; e.cnt = cnt;
        e.chk_wrap = cw; e.wr = wr;
        e.chk_scan = cs; e.sel = sel; e.wxyz = wx;
        exp_q.push_back(e);
    endfunction

    function automatic void push_cw(input int c, input string nm, input logic [15:0] cnt, input logic wr);
        push(c, nm, 1'b1, cnt, 1'b1, wr, 1'b0, 4'h0, 4'h0);
    endfunction

    function automatic void push_all(input int c, input string nm, input logic [15:0] cnt,
                                     input logic wr, input logic [3:0] sel, input logic [3:0] wx);
        push(c, nm, 1'b1, cnt, 1'b1, wr, 1'b1, sel, wx);
    endfunction

    task automatic compare(input exp_t e);
        logic [3:0] wxyz_now;
        wxyz_now = {W, X, Y, Z};
        if (e.chk_cnt) begin
            n_checks++;
            if (count === e.cnt) n_pass++;
            else $display("FAIL %s count: got %h want %h (cycle %0d)", e.name, count, e.cnt, e.cyc);
        end
        if (e.chk_wrap) begin
            n_checks++;
            if (wrap === e.wr) n_pass++;
            else $display("FAIL %s wrap: got %b want %b (cycle %0d)", e.name, wrap, e.wr, e.cyc);
        end
        if (e.chk_scan) begin
            n_checks++;
            if (dig_sel === e.sel) n_pass++;
            else $display("FAIL %s dig_sel: got %b want %b (cycle %0d)", e.name, dig_sel, e.sel, e.cyc);
            n_checks++;
            if (wxyz_now === e.wxyz) n_pass++;
            else $display("FAIL %s wxyz: got %h want %h (cycle %0d)", e.name, wxyz_now, e.wxyz, e.cyc);
        end
    endtask

    // Monitor: pops every expectation whose cycle has come and compares.
    initial begin
        forever begin
            @(negedge clk or posedge async_chk);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                mon_e = exp_q.pop_front();
                if (mon_e.cyc < cyc) begin
                    n_checks++;
                    $display("FAIL %s missed: observed at cycle %0d, required at cycle %0d", mon_e.name, cyc, mon_e.cyc);
                end else begin
                    compare(mon_e);
                end
            end
        end
    end

    // One cycle of stimulus; the DUT samples it at the next rising edge, so
    // the response is visible from cycle cyc+1.
    task automatic drive(input logic t, input logic u, input logic c, input logic l, input logic [15:0] v);
        @(negedge clk);
        tick = t; up = u; clr = c; load = l; load_val = v;
    endtask

    // Wait for the first cycle of scan index 0 (dig_sel just changed 1000 -> 0001).
    task automatic sync_idx0(output bit ok);
        logic [3:0] prev;
        ok = 1'b0;
        prev = dig_sel;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (dig_sel == 4'b0001 && prev == 4'b1000) ok = 1'b1;
            prev = dig_sel;
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL scan_sync: no 1000->0001 transition within 40 cycles, dig_sel=%b", dig_sel);
        end
    endtask

    // 16 cycles of scan starting one digit period after an index-0 start.
    task automatic scan_run(input logic [15:0] cnt);
        bit ok;
        int c;
        int idx;
        logic [15:0] sh;
        logic [3:0]  sel_one;
        sync_idx0(ok);
        if (ok) begin
            c = cyc;
            for (int k = 0; k < 16; k++) begin
                idx = (k / 4 + 1) % 4;
                sh = cnt >> (idx * 4);
                sel_one = 4'b0001 << idx;
                push_all(c + 4 + k, $sformatf("scan_%h_k%0d", cnt, k), cnt, 1'b0, sel_one, sh[3:0]);
            end
            repeat (22) drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        end
    endtask

    initial begin
        bit ok;
        int c;

        // Reset: requests during reset are ignored.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h1234);
        push_all(cyc + 1, "reset_state", 16'h0000, 1'b0, 4'b0001, 4'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);

        // Release with tick held: nothing may change on the first edge.
        @(negedge clk);
        rst_n = 1'b1; tick = 1'b1; up = 1'b1;
        push_all(cyc + 1, "release_edge1", 16'h0000, 1'b0, 4'b0001, 4'h0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        push_cw(cyc + 1, "clr_after_release", 16'h0000, 1'b0);

        // 1234 back-to-back up ticks; wrap must stay low throughout.
        for (int i = 0; i < 1234; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
            if (i == 9)         push_cw(cyc + 1, "up_10", 16'h0010, 1'b0);
            else if (i == 99)   push_cw(cyc + 1, "up_100", 16'h0100, 1'b0);
            else if (i == 999)  push_cw(cyc + 1, "up_1000", 16'h1000, 1'b0);
            else if (i == 1233) push_cw(cyc + 1, "up_1234", 16'h1234, 1'b0);
            else push(cyc + 1, "up_nowrap", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        push_cw(cyc + 1, "up_hold", 16'h1234, 1'b0);

        // 9998 -> 9999 -> 0000 -> 0001 with a single wrap pulse.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h9998); push_cw(cyc + 1, "ld_9998", 16'h9998, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000); push_cw(cyc + 1, "inc_9999", 16'h9999, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000); push_cw(cyc + 1, "inc_wrap", 16'h0000, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000); push_cw(cyc + 1, "inc_0001", 16'h0001, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000); push_cw(cyc + 1, "idle_0001", 16'h0001, 1'b0);

        // Down wrap, sanitised load, borrow chain.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000); push_cw(cyc + 1, "clr_0", 16'h0000, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000); push_cw(cyc + 1, "dec_wrap", 16'h9999, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000); push_cw(cyc + 1, "dec_after", 16'h9999, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 16'hAB5C); push_cw(cyc + 1, "ld_AB5C", 16'h0050, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h1000); push_cw(cyc + 1, "ld_1000", 16'h1000, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000); push_cw(cyc + 1, "dec_0999", 16'h0999, 1'b0);

        // Priority clr > load > tick.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0042); push_cw(cyc + 1, "ld_0042", 16'h0042, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h0777); push_cw(cyc + 1, "clr_ld_tick", 16'h0000, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0777); push_cw(cyc + 1, "ld_tick", 16'h0777, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h9999); push_cw(cyc + 1, "ld_9999", 16'h9999, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h1111); push_cw(cyc + 1, "ld_beats_wrap", 16'h1111, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000); push_cw(cyc + 1, "clr_1111", 16'h0000, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000); push_cw(cyc + 1, "clr_beats_dec", 16'h0000, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000); push_cw(cyc + 1, "idle_0000", 16'h0000, 1'b0);

        // Scan sequence at 0000 and at 1234.
        scan_run(16'h0000);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h1234); push_cw(cyc + 1, "ld_1234", 16'h1234, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        scan_run(16'h1234);

        // Scan output trails count by one cycle.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h1239); push_cw(cyc + 1, "ld_1239", 16'h1239, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        sync_idx0(ok);
        if (ok) begin
            load = 1'b1; load_val = 16'h0005;
            c = cyc;
            push_all(c + 1, "wxyz_lat_old", 16'h0005, 1'b0, 4'b0001, 4'h9);
            push_all(c + 2, "wxyz_lat_new", 16'h0005, 1'b0, 4'b0001, 4'h5);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h1234); push_cw(cyc + 1, "ld_1234_b", 16'h1234, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);

        // Asynchronous reset while digit 2 is displayed.
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (dig_sel == 4'b0100) ok = 1'b1;
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL async_sync: dig_sel never 0100 within 40 cycles, dig_sel=%b", dig_sel);
        end else begin
            #2 rst_n = 1'b0;
            #1;
            push_all(cyc, "async_reset", 16'h0000, 1'b0, 4'b0001, 4'h0);
            async_chk = 1'b1;
            #1 async_chk = 1'b0;
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        push_all(cyc + 1, "reset_hold", 16'h0000, 1'b0, 4'b0001, 4'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations never observed", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
